// File: rtl/tt_output_uart_logger.sv
// Change-logging monitor for the TinyTapeout uo_out bus. A strobed sample that
// differs from the last logged value becomes a {timestamp, data} record. The
// record is queued in a small FIFO and sent as four 8N1 UART bytes:
// 0xA5, ts[15:8], ts[7:0], data.
module tt_output_uart_logger #(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_en,
    input  logic [7:0]                    data_in,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CW    = $clog2(CLK_DIV);
    localparam int REC_W = TS_WIDTH + 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    tx_state_t state;
    tx_state_t state_nxt;

    logic [TS_WIDTH-1:0] ts;
    logic [7:0]          last_value;
    logic                last_valid;

    logic [REC_W-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level;

    logic [REC_W-1:0]    tx_rec;
    logic [CW-1:0]       baud_cnt;
    logic [2:0]          bit_idx;
    logic [1:0]          byte_idx;
    logic [7:0]          tx_byte;

    logic change;
    logic fifo_full;
    logic pop;
    logic wr_en;
    logic baud_done;

    // Internal handshake between capture and transmitter: the capture side
    // offers a record whenever 'change' is high and it is accepted (wr_en) only
    // if the FIFO has room at that edge, counting a same-cycle pop as room;
    // the transmitter takes a record (pop) only in IDLE with level != 0, so a
    // pop is never issued against an empty FIFO and nothing ever stalls.
    assign change    = sample_en && (!last_valid || (data_in != last_value));
    assign fifo_full = (level == LW'(FIFO_DEPTH));
    assign pop       = (state == S_IDLE) && (level != '0);
    assign wr_en     = change && (!fifo_full || pop);
    assign baud_done = (baud_cnt == CW'(CLK_DIV - 1));

    assign fifo_level = level;

    // Timestamp, change detection and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts         <= '0;
            last_value <= '0;
            last_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (sample_en) begin
                ts <= ts + TS_WIDTH'(1);
            end
            if (change) begin
                last_value <= data_in;
                last_valid <= 1'b1;
            end
            if (change && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Record storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {ts, data_in};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Transmitter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transmitter next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pop) state_nxt = S_START;
            S_START: if (baud_done) state_nxt = S_DATA;
            S_DATA:  if (baud_done && (bit_idx == 3'd7)) state_nxt = S_STOP;
            S_STOP:  if (baud_done) state_nxt = (byte_idx == 2'd3) ? S_IDLE : S_START;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit timer, bit/byte indices and the shift buffer holding the popped record.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_rec   <= '0;
        end else begin
            baud_cnt <= ((state == S_IDLE) || baud_done) ? '0 : baud_cnt + CW'(1);
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_rec   <= mem[rd_ptr];
                        byte_idx <= '0;
                    end
                end
                S_START: bit_idx <= '0;
                S_DATA:  if (baud_done) bit_idx <= bit_idx + 3'd1;
                S_STOP:  if (baud_done && (byte_idx != 2'd3)) byte_idx <= byte_idx + 2'd1;
                default: bit_idx <= '0;
            endcase
        end
    end

    // Serial line and busy flag decoded from the current state.
    always_comb begin
        case (byte_idx)
            2'd0:    tx_byte = SYNC_BYTE;
            2'd1:    tx_byte = tx_rec[23:16];
            2'd2:    tx_byte = tx_rec[15:8];
            default: tx_byte = tx_rec[7:0];
        endcase
        uart_tx = 1'b1;
        case (state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = tx_byte[bit_idx];
            default: uart_tx = 1'b1;
        endcase
        tx_busy = (state != S_IDLE);
    end

endmodule

// File: tb/tb_tt_output_uart_logger.sv
// Bench for tt_output_uart_logger: a queue-level reference model predicts which
// records are logged, dropped and when each is taken for transmission; a UART
// decoder on the serial line checks each decoded frame against that prediction.
module tb_tt_output_uart_logger;

    localparam int CLK_DIV   = 4;
    localparam int DEPTH     = 4;
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int FRAME_CYC = 40 * CLK_DIV;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          sample_en = 1'b0;
    logic [7:0]    data_in   = 8'h00;
    logic          uart_tx;
    logic          tx_busy;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    tt_output_uart_logger #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .TS_WIDTH   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .data_in    (data_in),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard state ----------------
    logic [23:0] exp_q[$];      // records expected on the line, in order
    int          exp_t_q[$];    // cycle at which each record's start bit must appear
    int          frames_rx = 0;
    bit          mon_busy  = 1'b0;

    // ---------------- reference model state ----------------
    logic [23:0] pend_q[$];     // records waiting in the FIFO
    logic [15:0] m_ts      = 16'h0000;
    logic [7:0]  m_last    = 8'h00;
    bit          m_valid   = 1'b0;
    int          busy_left = 0; // cycles the transmitter stays occupied
    bit          exp_ovf   = 1'b0;
    int          cyc       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a record is taken whenever the transmitter is free and
    // records are waiting; it then occupies the line for one full 4-byte frame.
    always @(posedge clk) begin : model
        int pre;
        bit do_pop;
        logic [23:0] rec;
        cyc++;
        if (!rst_n) begin
            pend_q.delete();
            exp_q.delete();
            exp_t_q.delete();
            m_ts      = 16'h0000;
            m_valid   = 1'b0;
            busy_left = 0;
            exp_ovf   = 1'b0;
        end else begin
            pre    = pend_q.size();
            do_pop = (busy_left == 0) && (pre > 0);
            if (do_pop) begin
                rec = pend_q.pop_front();
                exp_q.push_back(rec);
                exp_t_q.push_back(cyc);
                busy_left = FRAME_CYC;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            if (sample_en) begin
                if (!m_valid || (data_in != m_last)) begin
                    m_last  = data_in;
                    m_valid = 1'b1;
                    if ((pre == DEPTH) && !do_pop) exp_ovf = 1'b1;
                    else pend_q.push_back({m_ts, data_in});
                end
                m_ts = m_ts + 16'd1;
            end
        end
    end

    // ---------------- monitor: UART decoder ----------------
    logic samp [FRAME_CYC];

    initial begin : monitor
        int   start_cyc;
        bit   aborted;
        bit   framing_ok;
        bit   width_ok;
        int   base;
        logic v;
        logic [7:0] bytes [4];
        logic [23:0] rec;
        int   t;
        forever begin
            @(negedge clk);
            if (rst_n && (uart_tx === 1'b0)) begin
                mon_busy  = 1'b1;
                start_cyc = cyc;
                aborted   = 1'b0;
                for (int i = 0; i < FRAME_CYC; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[i] = uart_tx;
                end
                if (!aborted) begin
                    framing_ok = 1'b1;
                    width_ok   = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        for (int j = 0; j < 10; j++) begin
                            base = (b * 10 + j) * CLK_DIV;
                            v = samp[base + CLK_DIV / 2];
                            for (int s = 0; s < CLK_DIV; s++)
                                if (samp[base + s] !== v) width_ok = 1'b0;
                            if ((j == 0) && (v !== 1'b0)) framing_ok = 1'b0;
                            if ((j == 9) && (v !== 1'b1)) framing_ok = 1'b0;
                            if ((j >= 1) && (j <= 8)) bytes[b][j-1] = v;
                        end
                    end
                    frames_rx++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %02h %02h %02h %02h expected no frame",
                                 bytes[0], bytes[1], bytes[2], bytes[3]);
                    end else begin
                        rec = exp_q.pop_front();
                        t   = exp_t_q.pop_front();
                        check("sync_byte", {24'h0, bytes[0]}, 32'h0000_00A5);
                        check("record", {8'h00, bytes[1], bytes[2], bytes[3]}, {8'h00, rec});
                        check("start_cycle", start_cyc, t);
                        check("framing", {31'h0, framing_ok}, 32'd1);
                        check("bit_width", {31'h0, width_ok}, 32'd1);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic strobe(input logic [7:0] d);
        @(posedge clk);
        #1;
        sample_en = 1'b1;
        data_in   = d;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        frames_rx = 0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((n < 20000) &&
               !((exp_q.size() == 0) && (pend_q.size() == 0) && (busy_left == 0) && !mon_busy)) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_in_time", {31'h0, (n < 20000)}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int busy_cnt;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_uart_tx", {31'h0, uart_tx}, 32'd1);
        check("rst_tx_busy", {31'h0, tx_busy}, 32'd0);
        check("rst_overflow", {31'h0, overflow}, 32'd0);
        check("rst_fifo_level", {29'h0, fifo_level}, 32'd0);

        // Single record: latency and frame length
        frames_rx = 0;
        strobe(8'h00);
        idle();
        @(negedge clk);
        check("push_level", {29'h0, fifo_level}, 32'd1);
        check("line_idle_at_push", {31'h0, uart_tx}, 32'd1);
        @(negedge clk);
        check("start_latency", {31'h0, uart_tx}, 32'd0);
        check("pop_level", {29'h0, fifo_level}, 32'd0);
        busy_cnt = tx_busy ? 1 : 0;
        repeat (199) begin
            @(negedge clk);
            if (tx_busy) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, FRAME_CYC);
        wait_drain();
        check("single_overflow", {31'h0, overflow}, 32'd0);
        check("single_frames", frames_rx, 1);

        // Repeated value is not logged
        do_reset();
        strobe(8'h3C);
        strobe(8'h3C);
        strobe(8'h3D);
        idle();
        wait_drain();
        check("repeat_frames", frames_rx, 2);
        check("repeat_overflow", {31'h0, overflow}, 32'd0);

        // Burst of six changes: FIFO fills, sixth record dropped
        do_reset();
        for (int i = 0; i < 6; i++) strobe(8'h10 + 8'(i));
        idle();
        @(negedge clk);
        check("burst_level", {29'h0, fifo_level}, 32'd4);
        check("burst_overflow", {31'h0, overflow}, {31'h0, exp_ovf});
        check("burst_overflow_set", {31'h0, overflow}, 32'd1);
        wait_drain();
        check("overflow_sticky", {31'h0, overflow}, 32'd1);
        check("burst_frames", frames_rx, 5);

        // Random strobes over a small value set
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) strobe(8'($urandom_range(0, 3)));
            else idle();
        end
        idle();
        wait_drain();
        check("random_overflow", {31'h0, overflow}, {31'h0, exp_ovf});

        // Timestamp wrap
        do_reset();
        repeat (65535) strobe(8'h55);
        strobe(8'hAA);
        strobe(8'h55);
        idle();
        wait_drain();
        check("wrap_frames", frames_rx, 3);

        // Reset in the middle of byte 2's data bits
        do_reset();
        strobe(8'h11);
        strobe(8'h22);
        strobe(8'h33);
        idle();
        repeat (89) @(posedge clk);
        @(negedge clk);
        check("pre_reset_level", {29'h0, fifo_level}, 32'd2);
        check("pre_reset_busy", {31'h0, tx_busy}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_uart_tx", {31'h0, uart_tx}, 32'd1);
        check("abort_tx_busy", {31'h0, tx_busy}, 32'd0);
        check("abort_fifo_level", {29'h0, fifo_level}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("abort_frames", frames_rx, 0);
        strobe(8'h44);
        idle();
        wait_drain();
        check("post_abort_frames", frames_rx, 1);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation exceeded 200000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
